// File: rtl/image_pkg.sv
// Shared image-memory constants, pixel type, arbiter state and return-tag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package image_pkg;

    localparam int IMAGE_WIDTH  = 160;
    localparam int IMAGE_HEIGHT = 140;
    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 12;
    localparam int PIXEL_COUNT  = IMAGE_WIDTH * IMAGE_HEIGHT;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_DISP = 1'b0,
        OWNER_PROC = 1'b1
    } owner_t;

    // vld: a read result (or forced zero) is due in this slot for 'owner'.
    // zero: display address was out of range, return 0 instead of mem_q.
    // rpt: display was pre-empted in this slot, re-deliver the last pixel.
    typedef struct packed {
        logic   vld;
        owner_t owner;
        logic   zero;
        logic   rpt;
    } ret_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Delay line carrying one return tag per memory issue slot.
// Latency: RD_LATENCY cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, cleared by async reset.
module mem_arb_tag_pipe
    import image_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic     clk_in,
    input  logic     reset,
    input  ret_tag_t tag_in,
    output ret_tag_t tag_out
);

    ret_tag_t [RD_LATENCY-1:0] stage_q;
    ret_tag_t [RD_LATENCY-1:0] stage_d;

    // Shift the new tag in at stage 0, everything else moves one stage on.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_in;
        for (int i = 1; i < RD_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Tag stages; reset drops every read in flight.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/image_mem_arbiter.sv
// Shares single-port image memory between the display reader (fixed priority) and the processing engine.
// Latency: read data returns RD_LATENCY+1 cycles after the request cycle; proc_gnt is combinational.
// Backpressure: proc holds proc_req until proc_gnt; display never stalls. Optional writes: MEM_ARB_WRITE_EN.
module image_mem_arbiter #(
    parameter int ADDR_W       = image_pkg::ADDR_W,
    parameter int DATA_W       = image_pkg::DATA_W,
    parameter int IMAGE_WIDTH  = image_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = image_pkg::IMAGE_HEIGHT,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic              proc_gnt,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_rvalid,
    output logic              proc_err,
    output logic              starve,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    image_pkg::arb_state_t state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0]     mem_data_q, mem_data_d;
    logic [DATA_W-1:0]     disp_data_q, disp_data_d;
    logic                  disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]     proc_rdata_q, proc_rdata_d;
    logic                  proc_rvalid_q, proc_rvalid_d;
    image_pkg::ret_tag_t   tag_in, tag_out;

    logic starved, proc_wins, gnt, disp_oor, proc_oor, proc_wr;

    assign starved   = (state_q == image_pkg::STARVED);
    assign disp_oor  = (32'(disp_addr) >= 32'(PIXELS));
    assign proc_oor  = (32'(proc_addr) >= 32'(PIXELS));
    // Reset forces every output low, including the combinational grant.
    assign gnt       = ~reset & proc_req & (starved | ~disp_req);
    assign proc_wins = starved & proc_req;

`ifdef MEM_ARB_WRITE_EN
    assign proc_wr = proc_we;
`else
    assign proc_wr = 1'b0;
`endif

    // Next-state and starvation counter: count denied proc cycles, force a grant at the limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            image_pkg::NORMAL: begin
                if (!proc_req || gnt) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (proc_req && !gnt && cnt_d == CNT_W'(STARVE_LIMIT)) begin
                    state_d = image_pkg::STARVED;
                end
            end
            image_pkg::STARVED: begin
                // proc is served this cycle (or has withdrawn); either way go back.
                state_d = image_pkg::NORMAL;
                cnt_d   = '0;
            end
            default: begin
                state_d = image_pkg::NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and starvation counter.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= image_pkg::NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Issue: pick the winner, drive the memory pins and build the return tag for this slot.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_wren_d = 1'b0;
        mem_data_d = '0;
        tag_in     = '0;
        if (disp_req && !proc_wins) begin
            tag_in.vld   = 1'b1;
            tag_in.owner = image_pkg::OWNER_DISP;
            tag_in.zero  = disp_oor;
            if (!disp_oor) begin
                mem_addr_d = disp_addr;
            end
        end else if (gnt && !proc_oor) begin
            mem_addr_d = proc_addr;
            if (proc_wr) begin
                mem_wren_d = 1'b1;
                mem_data_d = proc_wdata;
            end else begin
                tag_in.vld   = 1'b1;
                tag_in.owner = image_pkg::OWNER_PROC;
            end
        end
        // Pre-empted display still gets a pixel so the raster timing is kept.
        tag_in.rpt = disp_req & proc_wins;
    end

    // Memory pin registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_wren_q <= 1'b0;
            mem_data_q <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_wren_q <= mem_wren_d;
            mem_data_q <= mem_data_d;
        end
    end

    mem_arb_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk_in  (clk_in),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Return stage: steer mem_q to its owner; disp_data holds so a repeat re-sends the last pixel.
    always_comb begin
        disp_valid_d  = tag_out.rpt | (tag_out.vld & (tag_out.owner == image_pkg::OWNER_DISP));
        disp_data_d   = disp_data_q;
        if (tag_out.vld && tag_out.owner == image_pkg::OWNER_DISP) begin
            disp_data_d = tag_out.zero ? '0 : mem_q;
        end
        proc_rvalid_d = tag_out.vld & (tag_out.owner == image_pkg::OWNER_PROC);
        proc_rdata_d  = proc_rvalid_d ? mem_q : proc_rdata_q;
    end

    // Return data registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            proc_rdata_q  <= '0;
            proc_rvalid_q <= 1'b0;
        end else begin
            disp_data_q   <= disp_data_d;
            disp_valid_q  <= disp_valid_d;
            proc_rdata_q  <= proc_rdata_d;
            proc_rvalid_q <= proc_rvalid_d;
        end
    end

    assign proc_gnt    = gnt;
    assign proc_err    = gnt & proc_oor;
    assign starve      = starved;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign proc_rdata  = proc_rdata_q;
    assign proc_rvalid = proc_rvalid_q;
    assign mem_addr    = mem_addr_q;

`ifdef MEM_ARB_WRITE_EN
    assign mem_wren = mem_wren_q;
    assign mem_data = mem_data_q;
`else
    logic unused_wr;
    assign unused_wr = ^{mem_wren_q, mem_data_q, proc_we, proc_wdata};
    assign mem_wren  = 1'b0;
    assign mem_data  = '0;
`endif

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
- Shares the single-port image memory (160x140 pixels, 12-bit RGB444, 15-bit address) between two requesters.
- Requester 1 is the VGA display reader, which is timing-critical.
- Requester 2 is the speed-detection processing engine, which reads and, optionally, writes pixels.
- Sits between vga_controller / processing engine and image_mem, and owns the memory address, write-enable and data pins.
- Display has fixed priority; a starvation guard guarantees forward progress for the processing engine.

Parameters:
- ADDR_W, 15, memory address width
- DATA_W, 12, pixel width
- IMAGE_WIDTH, 160, pixels per line
- IMAGE_HEIGHT, 140, lines per frame; valid addresses 0..IMAGE_WIDTH*IMAGE_HEIGHT-1 (0..22399)
- RD_LATENCY, 2, cycles from mem_addr registered to mem_q valid (registered altsyncram)
- STARVE_LIMIT, 64, consecutive denied proc cycles before forced grant

Ports:
- clk_in  in  1  memory/pixel clock
- reset  in  1  asynchronous, active-high
- disp_req  in  1  display read request this cycle
- disp_addr  in  ADDR_W  display pixel address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid
- proc_req  in  1  processing request, held until proc_gnt
- proc_we  in  1  1=write, 0=read (ignored unless write feature)
- proc_addr  in  ADDR_W  processing address
- proc_wdata  in  DATA_W  processing write data
- proc_gnt  out  1  combinational; request accepted this cycle
- proc_rdata  out  DATA_W  processing read data
- proc_rvalid  out  1  proc_rdata valid
- proc_err  out  1  one-cycle pulse, out-of-range proc address
- starve  out  1  arbiter in STARVED state
- mem_addr  out  ADDR_W  to image_mem address
- mem_wren  out  1  to image_mem write enable
- mem_data  out  DATA_W  to image_mem write data
- mem_q  in  DATA_W  from image_mem

Behaviour:
- Reset (async, immediate): all outputs 0; state NORMAL; starve counter 0; return-tag pipeline cleared. Reads in flight are discarded and produce no valid after reset.
- State NORMAL:
  - disp_req wins.
  - proc_gnt = proc_req & ~disp_req.
  - Each cycle with proc_req & ~proc_gnt increments the counter, saturating at STARVE_LIMIT.
- NORMAL -> STARVED when the counter reaches STARVE_LIMIT with proc_req still high.
- State STARVED:
  - proc wins: proc_gnt = proc_req.
  - A display request in the same cycle does not access memory. It returns the last delivered disp_data with normal latency and disp_valid=1.
- STARVED -> NORMAL on the cycle after the proc grant; counter cleared. The counter also clears on any proc grant in NORMAL, and when proc_req drops.
- Issue: the winning address is registered into mem_addr at the clock edge ending the request cycle. No winner: mem_addr holds, mem_wren=0.
- Read latency:
  - disp_valid/proc_rvalid assert exactly RD_LATENCY+1 cycles after the request cycle.
  - Data is registered from mem_q.
  - A tag pipeline of depth RD_LATENCY carries {owner, zero, repeat} per issue slot.
  - Back-to-back display reads every cycle: one result per cycle, no bubbles.
- Out-of-range display address (>=22400): no memory access; disp_data=0 with disp_valid at normal latency, preserving pixel timing.
- Out-of-range proc address:
  - proc_gnt=1 and proc_err=1 in the same cycle.
  - No memory access and no proc_rvalid.
  - Counts as a grant for starvation.
- proc_req with disp_req=0 every cycle: proc served every cycle, full throughput.

Optional Feature:
- MEM_ARB_WRITE_EN defined:
  - A granted proc request with proc_we=1 drives mem_wren=1 and mem_data=proc_wdata for one cycle, with mem_addr registered as for reads. No proc_rvalid is produced.
  - A display read of the same address issued the next cycle or later returns the new data.
- MEM_ARB_WRITE_EN undefined:
  - proc_we is ignored; every proc request is a read.
  - mem_wren is tied 0 and mem_data is tied 0.

Decomposition:
- Shared package image_pkg holds:
  - IMAGE_WIDTH, IMAGE_HEIGHT, ADDR_W, DATA_W and PIXEL_COUNT constants
  - a pixel_t typedef (12 bits)
  - arb_state_t enum {NORMAL, STARVED}
  - a return-tag struct {owner, zero, repeat}
- One sub-module, mem_arb_tag_pipe: parameterised RD_LATENCY shift register of tags, async-reset clear.

Test Plan:
- Display reads addr 0..159 every cycle, mem preloaded with data=addr -> disp_data 0..159 on consecutive cycles, first disp_valid 3 cycles after first request, no gaps.
- disp_req constantly high, proc_req held with addr 5 -> proc_gnt=0 for 64 cycles, starve=1 and proc_gnt=1 on cycle 65; that display slot returns the previous pixel; proc_rdata=mem[5] 3 cycles later; starve=0 next cycle.
- proc_addr=22400 with disp idle -> proc_gnt=1 and proc_err=1 same cycle, no proc_rvalid, mem_addr unchanged.
- disp_addr=30000 -> disp_valid after 3 cycles with disp_data=0.
- MEM_ARB_WRITE_EN: proc writes 0xABC to addr 100, then display reads 100 -> mem_wren one cycle, disp_data=0xABC.
- Assert reset with 2 reads in flight -> all outputs 0 immediately, no valids after release, state NORMAL.
